hsv_core_mem_response: RTL

HSV_CORE_MEM_RESPONSE -- requirements
Module: hsv_core_mem_response

---
 rtl/hsv_core_pkg.sv | 44 ++++
 rtl/hsv_core_mem_meta_fifo.sv | 49 ++++
 rtl/hsv_core_mem_response.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared core types: bus words, counters, tokens and read metadata.
// Also holds AXI response codes and the load-extract helper.
package hsv_core_pkg;

  typedef logic [31:0] word;
  typedef logic [3:0]  mem_counter;
  typedef logic [4:0]  insn_token;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2
  } mem_size_t;

  typedef struct packed {
    insn_token  token;
    logic [1:0] offset;
    mem_size_t  size;
    logic       is_unsigned;
  } mem_read_meta_t;

  typedef enum logic {
    RESP_RUN   = 1'b0,
    RESP_DRAIN = 1'b1
  } resp_state_t;

  function automatic word load_extract(word data, mem_read_meta_t m);
    word sh;
    word res;
    sh = data >> {m.offset, 3'b000};
    case (m.size)
      MEM_SIZE_B: res = {{24{~m.is_unsigned & sh[7]}}, sh[7:0]};
      MEM_SIZE_H: res = {{16{~m.is_unsigned & sh[15]}}, sh[15:0]};
      default:    res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hsv_core_mem_meta_fifo.sv
// Read-metadata FIFO; wrap-around pointers with an extra MSB.
// Head entry is visible combinationally on rdata.
module hsv_core_mem_meta_fifo
  import hsv_core_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic           clk_core,
  input  logic           rst_core_n,
  input  logic           push,
  input  mem_read_meta_t wdata,
  input  logic           pop,
  output mem_read_meta_t rdata
);

  localparam int AW = $clog2(Depth);

  logic [AW:0]    wptr_q;
  logic [AW:0]    rptr_q;
  mem_read_meta_t mem_q [Depth];
  logic           full;
  logic           empty;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_core) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  // Outstanding-read limits upstream keep these from ever firing.
  a_no_overflow : assert property (
    @(posedge clk_core) disable iff (!rst_core_n) !(push && full));
  a_no_underflow : assert property (
    @(posedge clk_core) disable iff (!rst_core_n) !(pop && empty));

endmodule

// File: rtl/hsv_core_mem_response.sv
// Memory response stage: R/B tracking, load formatting, flush drain.
// Define HSV_MEM_BUS_ERROR_EN to report SLVERR/DECERR on bus_error_o.
module hsv_core_mem_response
  import hsv_core_pkg::*;
#(
  parameter int MetaDepth = 4
) (
  input  logic           clk_core,
  input  logic           rst_core_n,
  input  logic           flush,
  input  logic           pending_reads_up,
  input  logic           pending_writes_up,
  input  mem_read_meta_t read_meta,
  input  logic           dmem_r_valid,
  output logic           dmem_r_ready,
  input  word            dmem_r_data,
  input  logic [1:0]     dmem_r_resp,
  input  logic           dmem_b_valid,
  output logic           dmem_b_ready,
  input  logic [1:0]     dmem_b_resp,
  output mem_counter     pending_reads,
  output mem_counter     pending_writes,
  output logic           fence_ready,
  output logic           valid_o,
  input  logic           stall_i,
  output word            result_o,
  output insn_token      token_o,
  output logic           bus_error_o,
  output logic           write_done_o
);

  resp_state_t    state_q;
  resp_state_t    state_d;
  mem_read_meta_t head;
  logic           drain;
  logic           hold;
  logic           r_hs;
  logic           r_fire;
  logic           b_fire;
  logic           load;
  logic           valid_d;
  logic           resp_err;
  word            load_data;

  assign drain        = (state_q == RESP_DRAIN);
  assign hold         = valid_o & stall_i;
  assign dmem_r_ready = ~hold | drain;
  assign dmem_b_ready = 1'b1;
  assign r_hs         = dmem_r_valid & dmem_r_ready;
  // A beat with nothing outstanding is dropped entirely.
  assign r_fire       = r_hs & (pending_reads != '0);
  assign b_fire       = dmem_b_valid & (pending_writes != '0);
  assign load         = r_fire & ~drain & ~flush;
  assign fence_ready  = (pending_reads == '0) & (pending_writes == '0);

`ifdef HSV_MEM_BUS_ERROR_EN
  logic unused_b_resp;
  assign unused_b_resp = ^dmem_b_resp;
  assign resp_err = (dmem_r_resp == AXI_RESP_SLVERR) |
                    (dmem_r_resp == AXI_RESP_DECERR);
`else
  logic unused_resp;
  assign unused_resp = ^{dmem_r_resp, dmem_b_resp};
  assign resp_err    = 1'b0;
`endif

  assign load_data = resp_err ? '0 : load_extract(dmem_r_data, head);

  hsv_core_mem_meta_fifo #(
    .Depth(MetaDepth)
  ) u_meta_fifo (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .push      (pending_reads_up),
    .wdata     (read_meta),
    .pop       (r_fire),
    .rdata     (head)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESP_RUN:
        if (flush && ((pending_reads != '0) || r_hs)) state_d = RESP_DRAIN;
      RESP_DRAIN:
        if (pending_reads == '0) state_d = RESP_RUN;
      default: state_d = RESP_RUN;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    if (!flush) valid_d = load | hold;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q        <= RESP_RUN;
      pending_reads  <= '0;
      pending_writes <= '0;
      valid_o        <= 1'b0;
      write_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_o      <= valid_d;
      write_done_o <= b_fire & ~flush;
      if (pending_reads_up && !r_fire)
        pending_reads <= pending_reads + 1'b1;
      else if (!pending_reads_up && r_fire)
        pending_reads <= pending_reads - 1'b1;
      if (pending_writes_up && !b_fire)
        pending_writes <= pending_writes + 1'b1;
      else if (!pending_writes_up && b_fire)
        pending_writes <= pending_writes - 1'b1;
    end
  end

`ifdef HSV_MEM_BUS_ERROR_EN
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      bus_error_o <= 1'b0;
    end else if (load) begin
      bus_error_o <= resp_err;
    end else if (!(hold && !flush)) begin
      bus_error_o <= 1'b0;
    end
  end
`else
  assign bus_error_o = 1'b0;
`endif

  always_ff @(posedge clk_core) begin
    if (load) begin
      result_o <= load_data;
      token_o  <= head.token;
    end
  end

endmodule
